// File: rtl/control_puertas_param.sv
// Clocked elevator door controller: closed/opening/open/closing FSM with internal
// travel and dwell timing, sensor/button reversal, nudge mode and motion safety flag.
module control_puertas_param #(
    parameter int N_PISOS         = 4,
    parameter int T_MOV           = 16,
    parameter int T_ESPERA        = 64,
    parameter int MAX_REAPERTURAS = 3,
    parameter int W_PISO          = $clog2(N_PISOS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_PISO-1:0]  piso_actual,
    input  logic               moviendo,
    input  logic               subiendo,
    input  logic [N_PISOS-1:0] llamada_cabina,
    input  logic [N_PISOS-1:0] llamada_sube,
    input  logic [N_PISOS-1:0] llamada_baja,
    input  logic               boton_abrir,
    input  logic               boton_cerrar,
    input  logic               sensor,
    output logic [1:0]         motor_puerta,
    output logic [1:0]         estado_puertas,
    output logic [N_PISOS-1:0] aviso,
    output logic [N_PISOS-1:0] atendido,
    output logic               zumbador,
    output logic               trabajando,
    output logic               error_mov
);
    localparam int T_MAX = (T_MOV > T_ESPERA) ? T_MOV : T_ESPERA;
    localparam int CW    = $clog2(T_MAX);
    localparam int RW    = $clog2(MAX_REAPERTURAS + 1);
    localparam logic [CW-1:0] MOV_FIN  = CW'(T_MOV - 1);
    localparam logic [CW-1:0] ESP_FIN  = CW'(T_ESPERA - 1);
    localparam logic [RW-1:0] REAP_MAX = RW'(MAX_REAPERTURAS);

    // Encoding chosen so the state register doubles as the estado_puertas output.
    typedef enum logic [1:0] {
        CERRADA  = 2'b00,
        ABIERTA  = 2'b01,
        CERRANDO = 2'b10,
        ABRIENDO = 2'b11
    } estado_t;

    estado_t             state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [RW-1:0]       reap_q, reap_d;
    logic                nudge_q, nudge_d;
    logic [1:0]          motor_q, motor_d;
    logic [N_PISOS-1:0]  aviso_q, aviso_d;
    logic [N_PISOS-1:0]  atendido_q, atendido_d;
    logic                zumbador_q, zumbador_d;
    logic                error_q, error_d;

    logic [N_PISOS-1:0]  piso_oh;
    logic [N_PISOS-1:0]  servicio_vec;
    logic                piso_valido;
    logic                servicio;
    logic                sensor_ef;
    logic                reversa;

    assign piso_valido = ({1'b0, piso_actual} < (W_PISO + 1)'(N_PISOS));

    // Hall calls only count when they match the travel direction, except at the end floors.
    for (genvar gi = 0; gi < N_PISOS; gi++) begin : g_piso
        assign piso_oh[gi] = piso_valido && (piso_actual == W_PISO'(gi));
        assign servicio_vec[gi] = piso_oh[gi] &
            (llamada_cabina[gi] |
             (llamada_sube[gi] & (subiendo | (gi == 0))) |
             (llamada_baja[gi] & (~subiendo | (gi == N_PISOS - 1))));
    end

    assign servicio  = ~moviendo & (|servicio_vec);
    assign sensor_ef = sensor & ~nudge_q;
    assign reversa   = boton_abrir | sensor_ef;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        reap_d  = reap_q;
        nudge_d = nudge_q;
        case (state_q)
            CERRADA: begin
                if (!moviendo && (servicio || boton_abrir)) begin
                    state_d = ABRIENDO;
                    cnt_d   = '0;
                end
            end
            ABRIENDO: begin
                if (cnt_q == MOV_FIN) begin
                    state_d = ABIERTA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ABIERTA: begin
                if (boton_abrir || sensor_ef) begin
                    cnt_d = '0;
                end else if (boton_cerrar || cnt_q == ESP_FIN) begin
                    state_d = CERRANDO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CERRANDO: begin
                // A reversal reopens only over the distance already closed.
                if (reversa) begin
                    state_d = ABRIENDO;
                    cnt_d   = MOV_FIN - cnt_q;
                    if (sensor_ef && reap_q != REAP_MAX) reap_d = reap_q + RW'(1);
                end else if (cnt_q == MOV_FIN) begin
                    state_d = CERRADA;
                    cnt_d   = '0;
                    reap_d  = '0;
                    nudge_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
        if (reap_d == REAP_MAX) nudge_d = 1'b1;

        motor_d    = (state_d == ABRIENDO) ? 2'b01 :
                     (state_d == CERRANDO) ? 2'b10 : 2'b00;
        aviso_d    = (state_q == CERRADA && state_d == ABRIENDO && servicio) ? piso_oh : '0;
        atendido_d = (state_q != ABIERTA && state_d == ABIERTA) ? piso_oh : '0;
        zumbador_d = nudge_d & (state_d == CERRANDO);
        error_d    = error_q | (moviendo & (state_q != CERRADA));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CERRADA;
            cnt_q      <= '0;
            reap_q     <= '0;
            nudge_q    <= 1'b0;
            motor_q    <= 2'b00;
            aviso_q    <= '0;
            atendido_q <= '0;
            zumbador_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reap_q     <= reap_d;
            nudge_q    <= nudge_d;
            motor_q    <= motor_d;
            aviso_q    <= aviso_d;
            atendido_q <= atendido_d;
            zumbador_q <= zumbador_d;
            error_q    <= error_d;
        end
    end

    assign motor_puerta   = motor_q;
    assign estado_puertas = state_q;
    assign aviso          = aviso_q;
    assign atendido       = atendido_q;
    assign zumbador       = zumbador_q;
    assign error_mov      = error_q;
    assign trabajando     = (state_q != CERRADA) | servicio;

endmodule
